// File: rtl/prio_pkg.sv
// Shared types and constants for the priority-encoder arbiter.
// Holds the index-width helper, the mode encodings and the FSM state type.
package prio_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/prio_encoder_arb_if.sv
// Request/grant bundle between request sources, the arbiter and the shared consumer.
// The request side also owns the cascade enable and the consumer's ack.
interface prio_encoder_arb_if #(parameter int N = 8) ();
    localparam int W = prio_pkg::clog2(N);

    logic         ei;
    logic [N-1:0] req;
    logic         rr_mode;
    logic         ack;
    logic [W-1:0] y;
    logic         valid;
    logic         gs;
    logic         eo;

    modport master (output ei, req, rr_mode, ack, input y, valid, gs, eo);
    modport slave  (input ei, req, rr_mode, ack, output y, valid, gs, eo);
endinterface

// File: rtl/prio_find.sv
// Combinational search for the first set request scanning downward from s-1,
// wrapping through N-1 back to s.
module prio_find #(
    parameter int N = 8,
    localparam int W = prio_pkg::clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] s,
    output logic [W-1:0] idx,
    output logic         found
);

    logic [W-1:0] cand;

    // Walk from the farthest candidate to the nearest so the nearest one wins.
    // W-bit subtraction gives the modulo-N wrap because N is a power of two.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = N; k >= 1; k--) begin
            cand = s - W'(k);
            if (req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_encoder_arb.sv
// Registered N-input priority encoder with valid/ack grant handshake,
// fixed or round-robin selection, and ei/eo/gs cascade outputs.
module prio_encoder_arb
    import prio_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    prio_encoder_arb_if.slave    bus
);

    localparam int W = clog2(N);

    state_t       state_q, state_d;
    logic [W-1:0] y_q, y_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] start;
    logic [W-1:0] win_idx;
    logic         win_found;

    // Fixed priority is simply the round-robin search anchored at 0.
    assign start = (bus.rr_mode == MODE_RR) ? ptr_q : '0;

    prio_find #(.N(N)) u_find (
        .req   (bus.req),
        .s     (start),
        .idx   (win_idx),
        .found (win_found)
    );

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.ei && win_found) begin
                    state_d = ST_GRANT;
                    y_d     = win_idx;
                end
            end
            ST_GRANT: begin
                // ack wins over a simultaneous ei drop; only ack advances the pointer.
                if (bus.ack) begin
                    state_d = ST_IDLE;
                    ptr_d   = y_q;
                end else if (!bus.ei) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.y     = y_q;
    assign bus.valid = (state_q == ST_GRANT);
    assign bus.gs    = bus.ei & (|bus.req);
    assign bus.eo    = bus.ei & ~(|bus.req);

endmodule

// File: doc/prio_encoder_arb.md
Name: prio_encoder_arb

Overview:
- Parametrised, registered N-input priority encoder with a valid/ack grant handshake.
- Supports fixed-priority and round-robin selection, chosen at run time by a mode input.
- Provides ei/eo/gs cascade signals so several blocks can be chained into wider encoders.
- Sits between request sources (buttons, peripheral IRQ lines) and a single shared consumer on the Basys 3 designs.

Parameters:
- N, 8, number of request lines; power of two, N ≥ 2.
- W, clog2(N), grant index width; localparam, derived, not overridable.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ei  input  1  enable input; 0 blocks new grants.
- req  input  N  request vector; bit N-1 is the highest fixed priority.
- rr_mode  input  1  0 = fixed priority, 1 = round-robin; sampled only in IDLE.
- ack  input  1  consumer accepts the current grant.
- y  output  W  registered index of the granted request.
- valid  output  1  registered; y holds a live grant.
- gs  output  1  combinational group signal: ei & |req.
- eo  output  1  combinational enable output: ei & ~|req.

Behaviour:
- Reset (async, rst_n = 0): y = 0, valid = 0, round-robin pointer ptr = 0, state = IDLE. Takes effect immediately, including mid-grant. gs and eo follow their combinational equations during reset.
- States:
  - IDLE, valid = 0.
  - GRANT, valid = 1.
- IDLE → GRANT: on a clock edge with ei = 1 and |req = 1.
  - Winner is registered into y; valid = 1 from the next cycle.
  - Latency from req to valid/y is exactly 1 clock.
- Fixed mode (rr_mode = 0): winner is the highest set index.
- Round-robin mode (rr_mode = 1):
  - Search order is ptr-1, ptr-2, … down to 0, then wraps from N-1 down to ptr (indices mod N); the first set bit wins.
  - With ptr = 0 the order is N-1 … 0, identical to fixed mode.
- GRANT behaviour:
  - y and valid are held stable regardless of req changes until ack = 1 or ei = 0.
  - Requests dropped while granted do not cancel the grant.
- GRANT → IDLE on ack = 1: valid = 0 next cycle; ptr ← y in both modes.
- GRANT → IDLE on ei = 0 without ack: valid = 0 next cycle; ptr unchanged (abort).
- ack and ei = 0 in the same cycle: treated as ack, so ptr updates.
- After every grant there is one mandatory IDLE cycle; maximum grant rate is 1 per 2 clocks.
- ack while valid = 0 is ignored.
- y retains its last value in IDLE; it is meaningful only when valid = 1.
- req = 0 in IDLE: no transition; eo = ei; gs = 0.
- rr_mode changes while in GRANT: ignored until the next IDLE decision.
- Cascade: eo of the higher-priority block drives ei of the next lower block. gs of each block marks which group is active.

Decomposition:
- Shared package/header prio_pkg holds:
  - clog2 constant function
  - mode constants MODE_FIXED = 0, MODE_RR = 1
  - state encodings ST_IDLE = 1'b0, ST_GRANT = 1'b1
- Sub-module prio_find (combinational, parametrised by N):
  - Inputs: req, start index s.
  - Function: rotates req, finds the first set bit scanning downward from s-1 with wrap, returns its index and a found flag.
  - Fixed mode drives s = 0; round-robin mode drives s = ptr.
  - Top level holds the FSM, registers and cascade logic.

Test Plan (N = 8):
1. Fixed priority:
   - Stimulus: rr_mode = 0, ei = 1, req = 8'b0010_0110.
   - Response: gs = 1 and eo = 0 immediately; after 1 clk valid = 1, y = 5.
2. Hold and re-arbitrate:
   - Stimulus: from scenario 1, change req to 8'h80 and hold ack = 0 for 5 clks; then pulse ack.
   - Response: y stays 5 and valid stays 1 throughout; valid = 0 the clk after ack; one clk later valid = 1, y = 7.
3. Round-robin, all requesting:
   - Stimulus: rr_mode = 1, req = 8'hFF held, ack asserted 1 clk after each valid.
   - Response: grant sequence 7, 6, 5, 4, 3, 2, 1, 0, 7 — one grant every 2 clks.
4. Round-robin fairness:
   - Stimulus: rr_mode = 1, req = 8'b1000_0001, ack after each grant.
   - Response: grants alternate 7, 0, 7, 0. In fixed mode the same stimulus gives 7, 7, 7.
5. Enable and cascade:
   - Stimulus A: ei = 0, req = 8'h0F for 4 clks. Response A: valid = 0, gs = 0, eo = 0.
   - Stimulus B: ei = 1, req = 0. Response B: eo = 1, gs = 0, valid = 0.
   - Stimulus C: ei dropped during GRANT (y = 3, no ack). Response C: valid = 0 next clk, ptr unchanged.
6. Reset mid-operation:
   - Stimulus: rst_n pulled low asynchronously (between edges) while valid = 1, y = 6, rr_mode = 1.
   - Response: valid = 0 and y = 0 immediately. After release with req = 8'hFF, first grant is y = 7 (ptr = 0).
